// File: rtl/alu_cmd_queue.sv
// Command buffer in front of the ALU: filters illegal opcodes and holds legal
// {op, a, b} commands in an in-order first-word-fall-through queue.
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int CNTW  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [DW-1:0]                in_a,
    input  logic [DW-1:0]                in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_op,
    output logic [DW-1:0]                out_a,
    output logic [DW-1:0]                out_b,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err_illegal,
    output logic [CNTW-1:0]              illegal_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [1:0]    OP_ILLEGAL = 2'd3;

    logic [1:0]      memOpQ [DEPTH];
    logic [DW-1:0]   memAQ  [DEPTH];
    logic [DW-1:0]   memBQ  [DEPTH];

    logic [PW-1:0]   rdPtrQ, rdPtrD;
    logic [PW-1:0]   wrPtrQ, wrPtrD;
    logic [CW-1:0]   countQ, countD;
    logic            errQ, errD;
    logic [CNTW-1:0] illCntQ, illCntD;

    logic            acceptEn;
    logic            pushLegal;
    logic            pushIllegal;
    logic            popEn;

    // Handshake decode: ready depends only on stored occupancy, never on out_ready
    always_comb begin
        in_ready    = (countQ < FULL_COUNT);
        out_valid   = (countQ != '0);
        acceptEn    = in_valid && in_ready;
        pushLegal   = acceptEn && (in_op != OP_ILLEGAL);
        pushIllegal = acceptEn && (in_op == OP_ILLEGAL);
        popEn       = out_valid && out_ready;
    end

    // Next-state for pointers, occupancy and the illegal-command bookkeeping
    always_comb begin
        wrPtrD  = wrPtrQ;
        rdPtrD  = rdPtrQ;
        countD  = countQ;
        errD    = pushIllegal;
        illCntD = illCntQ;

        if (pushLegal) begin
            wrPtrD = (wrPtrQ == LAST_PTR) ? '0 : wrPtrQ + 1'b1;
        end
        if (popEn) begin
            rdPtrD = (rdPtrQ == LAST_PTR) ? '0 : rdPtrQ + 1'b1;
        end

        case ({pushLegal, popEn})
            2'b10:   countD = countQ + 1'b1;
            2'b01:   countD = countQ - 1'b1;
            default: countD = countQ;
        endcase

        if (pushIllegal && (illCntQ != '1)) begin
            illCntD = illCntQ + 1'b1;
        end
    end

    // Control state register; reset discards everything queued
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrQ  <= '0;
            rdPtrQ  <= '0;
            countQ  <= '0;
            errQ    <= 1'b0;
            illCntQ <= '0;
        end else begin
            wrPtrQ  <= wrPtrD;
            rdPtrQ  <= rdPtrD;
            countQ  <= countD;
            errQ    <= errD;
            illCntQ <= illCntD;
        end
    end

    // Command storage is deliberately left unreset; only legal commands are written
    always_ff @(posedge clk) begin
        if (!rst && pushLegal) begin
            memOpQ[wrPtrQ] <= in_op;
            memAQ[wrPtrQ]  <= in_a;
            memBQ[wrPtrQ]  <= in_b;
        end
    end

    // Head of queue falls through to the ALU, zeroed whenever nothing is valid
    always_comb begin
        out_op = '0;
        out_a  = '0;
        out_b  = '0;
        if (out_valid) begin
            out_op = memOpQ[rdPtrQ];
            out_a  = memAQ[rdPtrQ];
            out_b  = memBQ[rdPtrQ];
        end
        count       = countQ;
        err_illegal = errQ;
        illegal_cnt = illCntQ;
    end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: a scoreboard queue records every
// legal accepted command and is compared in order against each ALU pop.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CNTW  = 8;

    typedef struct packed {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } cmd_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_op;
    logic [DW-1:0]   out_a;
    logic [DW-1:0]   out_b;
    logic [2:0]      count;
    logic            err_illegal;
    logic [CNTW-1:0] illegal_cnt;

    cmd_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   popsSeen = 0;

    alu_cmd_queue #(.DEPTH(DEPTH), .DW(DW), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_a       (out_a),
        .out_b       (out_b),
        .count       (count),
        .err_illegal (err_illegal),
        .illegal_cnt (illegal_cnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: sampled mid-cycle, records accepts and checks pops in order
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready && in_op != 2'd3) begin
                sbQ.push_back('{op: in_op, a: in_a, b: in_b});
            end
            if (out_valid && out_ready) begin
                cmd_t exp;
                checks++;
                popsSeen++;
                if (sbQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL sb_underflow: got op=%0d a=%0h b=%0h, expected no pop", out_op, out_a, out_b);
                end else begin
                    exp = sbQ.pop_front();
                    if ({out_op, out_a, out_b} !== {exp.op, exp.a, exp.b}) begin
                        failures++;
                        $display("[TB] FAIL sb_order: got op=%0d a=%0h b=%0h, expected op=%0d a=%0h b=%0h",
                                 out_op, out_a, out_b, exp.op, exp.a, exp.b);
                    end
                end
            end
        end
    end

    // Watchdog so a stuck handshake cannot hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (count == 0) break;
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got count=%0d sb=%0d, expected count=0 sb=0", count, sbQ.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        step(); step();
        rst = 1'b0;
        sbQ.delete();
        checks++;
        if ({count, out_valid, in_ready, err_illegal, illegal_cnt} !== {3'd0, 1'b0, 1'b1, 1'b0, 8'd0}) begin
            failures++;
            $display("[TB] FAIL reset_state: got count=%0d ov=%0b ir=%0b err=%0b ill=%0d, expected 0 0 1 0 0",
                     count, out_valid, in_ready, err_illegal, illegal_cnt);
        end
        checks++;
        if ({out_op, out_a, out_b} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got op=%0d a=%0h b=%0h, expected zeros", out_op, out_a, out_b);
        end
    endtask

    task automatic test_single();
        drive_cmd(2'd0, 32'd50, 32'd30);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_op, out_a, out_b, count} !== {1'b1, 2'd0, 32'd50, 32'd30, 3'd1}) begin
            failures++;
            $display("[TB] FAIL single_latency: got ov=%0b op=%0d a=%0d b=%0d count=%0d, expected 1 0 50 30 1",
                     out_valid, out_op, out_a, out_b, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, out_op, out_a, out_b, count} !== '0) begin
            failures++;
            $display("[TB] FAIL single_pop: got ov=%0b op=%0d a=%0h b=%0h count=%0d, expected all 0",
                     out_valid, out_op, out_a, out_b, count);
        end
    endtask

    task automatic fill_four();
        drive_cmd(2'd0, 32'd50, 32'd30); step();
        drive_cmd(2'd1, 32'd50, 32'd30); step();
        drive_cmd(2'd2, 32'd50, 32'd30); step();
        drive_cmd(2'd0, 32'd7, -32'sd3); step();
        in_valid = 1'b0;
    endtask

    task automatic test_fill_stall();
        fill_four();
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_full: got count=%0d ir=%0b, expected 4 0", count, in_ready);
        end
        drive_cmd(2'd1, 32'd99, -32'sd1);
        step(); step();
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || out_op !== 2'd0 || out_a !== 32'd50) begin
            failures++;
            $display("[TB] FAIL fill_stall: got count=%0d ir=%0b op=%0d a=%0d, expected 4 0 0 50",
                     count, in_ready, out_op, out_a);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("[TB] FAIL fill_first_pop: got count=%0d, expected 3", count);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("[TB] FAIL fill_push_pop: got count=%0d, expected 3", count);
        end
        drain();
    endtask

    task automatic test_full_simul();
        fill_four();
        drive_cmd(2'd2, 32'd11, 32'd12);
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_ready: got ir=%0b, expected 0", in_ready);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("[TB] FAIL full_no_accept: got count=%0d, expected 3", count);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL full_late_accept: got count=%0d, expected 4", count);
        end
        drain();
    endtask

    task automatic test_illegal();
        drive_cmd(2'd2, 32'd5, 32'd6);
        step();
        drive_cmd(2'd3, 32'd1, 32'd2);
        step();
        in_valid = 1'b0;
        checks++;
        if ({err_illegal, illegal_cnt, count, out_valid} !== {1'b1, 8'd1, 3'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL illegal_drop: got err=%0b ill=%0d count=%0d ov=%0b, expected 1 1 1 1",
                     err_illegal, illegal_cnt, count, out_valid);
        end
        step();
        checks++;
        if (err_illegal !== 1'b0 || illegal_cnt !== 8'd1) begin
            failures++;
            $display("[TB] FAIL illegal_pulse: got err=%0b ill=%0d, expected 0 1", err_illegal, illegal_cnt);
        end
        drive_cmd(2'd3, 32'd3, 32'd4);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({err_illegal, illegal_cnt, count, out_valid} !== {1'b1, 8'd2, 3'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL illegal_with_pop: got err=%0b ill=%0d count=%0d ov=%0b, expected 1 2 0 0",
                     err_illegal, illegal_cnt, count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int startPops = popsSeen;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_cmd(2'(i % 3), 32'(100 + i), 32'(i * 3));
            step();
            checks++;
            if (count !== 3'd1) begin
                failures++;
                $display("[TB] FAIL b2b_count_%0d: got count=%0d, expected 1", i, count);
            end
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (popsSeen - startPops != 10) begin
            failures++;
            $display("[TB] FAIL b2b_pops: got %0d pops, expected 10", popsSeen - startPops);
        end
    endtask

    task automatic test_mid_reset();
        drive_cmd(2'd0, 32'd1, 32'd1); step();
        drive_cmd(2'd1, 32'd2, 32'd2); step();
        drive_cmd(2'd2, 32'd3, 32'd3); step();
        drive_cmd(2'd0, 32'd4, 32'd4);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sbQ.delete();
        checks++;
        if ({count, out_valid, in_ready, illegal_cnt} !== {3'd0, 1'b0, 1'b1, 8'd0}) begin
            failures++;
            $display("[TB] FAIL mid_reset: got count=%0d ov=%0b ir=%0b ill=%0d, expected 0 0 1 0",
                     count, out_valid, in_ready, illegal_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            drive_cmd(2'd3, 32'(i), 32'(~i));
            step();
            if (i == 254) begin
                checks++;
                if (illegal_cnt !== 8'd255) begin
                    failures++;
                    $display("[TB] FAIL sat_reach: got ill=%0d, expected 255", illegal_cnt);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (illegal_cnt !== 8'd255 || count !== 3'd0 || err_illegal !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_hold: got ill=%0d count=%0d err=%0b, expected 255 0 1",
                     illegal_cnt, count, err_illegal);
        end
        step();
        checks++;
        if (err_illegal !== 1'b0 || illegal_cnt !== 8'd255) begin
            failures++;
            $display("[TB] FAIL sat_idle: got err=%0b ill=%0d, expected 0 255", err_illegal, illegal_cnt);
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_full_simul();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
